i2c_master_byte: RTL and testbench

Single-byte I2C master that sits directly upstream of the team's I2C slave. It converts one command word from the SPI front end (7-bit address, R/W, data byte) into a complete I2C transaction on i2c_scl/i2c_sda: START, address+R/W, ACK, data, ACK/NACK, STOP. It reports completion, acknowledge errors and read data back to the SPI side.

---
 rtl/i2c_master_byte.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_master_byte.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL is push-pull; SDA is open-drain (driven low or released) and needs an external pull-up.
module i2c_master_byte #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       i2c_scl,
  inout  wire        i2c_sda
);

  localparam int unsigned QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_ACK1  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_ACK2  = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]    state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]    quarter, quarter_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    addr_sr, addr_n;
  logic [7:0]    data_sr, data_n;
  logic          rw_q, rw_n;
  logic          ack_bit, ack_bit_n;
  logic          sda_low, sda_low_n;
  logic          scl_n;
  logic          ready_n, busy_n, done_n, ack_err_n;
  logic [7:0]    rd_n;
  logic          q_last, sample, bit_end;

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

  assign q_last  = (qcnt == QLAST);
  assign sample  = q_last && (quarter == 2'd2);
  assign bit_end = q_last && (quarter == 2'd3);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      quarter   <= 2'd0;
      bit_idx   <= 3'd0;
      addr_sr   <= 8'h00;
      data_sr   <= 8'h00;
      rw_q      <= 1'b0;
      ack_bit   <= 1'b1;
      sda_low   <= 1'b0;
      i2c_scl   <= 1'b1;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      state     <= state_n;
      qcnt      <= qcnt_n;
      quarter   <= quarter_n;
      bit_idx   <= bit_n;
      addr_sr   <= addr_n;
      data_sr   <= data_n;
      rw_q      <= rw_n;
      ack_bit   <= ack_bit_n;
      sda_low   <= sda_low_n;
      i2c_scl   <= scl_n;
      cmd_ready <= ready_n;
      busy      <= busy_n;
      done      <= done_n;
      ack_err   <= ack_err_n;
      rd_data   <= rd_n;
    end
  end

  // Next-state, bit timing and bus drive
  always_comb begin
    state_n   = state;
    qcnt_n    = qcnt;
    quarter_n = quarter;
    bit_n     = bit_idx;
    addr_n    = addr_sr;
    data_n    = data_sr;
    rw_n      = rw_q;
    ack_bit_n = ack_bit;
    ready_n   = cmd_ready;
    busy_n    = busy;
    done_n    = 1'b0;
    ack_err_n = ack_err;
    rd_n      = rd_data;
    scl_n     = 1'b1;
    sda_low_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n   = S_START;
          qcnt_n    = '0;
          quarter_n = 2'd0;
          bit_n     = 3'd0;
          addr_n    = {cmd_addr, cmd_rw};
          data_n    = cmd_data;
          rw_n      = cmd_rw;
          ack_err_n = 1'b0;
          ready_n   = 1'b0;
          busy_n    = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
      end
      default: begin
        if (q_last) begin
          qcnt_n    = '0;
          quarter_n = quarter + 2'd1;
        end else begin
          qcnt_n = qcnt + QW'(1);
        end
        // SDA is sampled on the last clock of the first SCL-high quarter
        if (sample) begin
          ack_bit_n = i2c_sda;
          if (state == S_DATA && rw_q) data_n = {data_sr[6:0], i2c_sda};
        end
        if (bit_end) begin
          case (state)
            S_START: begin
              state_n = S_ADDR;
              bit_n   = 3'd0;
            end
            S_ADDR: begin
              if (bit_idx == 3'd7) begin
                state_n = S_ACK1;
              end else begin
                bit_n  = bit_idx + 3'd1;
                addr_n = {addr_sr[6:0], 1'b0};
              end
            end
            S_ACK1: begin
              if (ack_bit) begin
                ack_err_n = 1'b1;
                state_n   = S_STOP;
              end else begin
                state_n = S_DATA;
                bit_n   = 3'd0;
              end
            end
            S_DATA: begin
              if (bit_idx == 3'd7) begin
                state_n = S_ACK2;
              end else begin
                bit_n = bit_idx + 3'd1;
                if (!rw_q) data_n = {data_sr[6:0], 1'b0};
              end
            end
            S_ACK2: begin
              if (!rw_q && ack_bit) ack_err_n = 1'b1;
              state_n = S_STOP;
            end
            S_STOP: begin
              state_n = S_DONE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
              if (rw_q && !ack_err) rd_n = data_sr;
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
    endcase

    // Bus levels follow the next state so they change on quarter boundaries
    case (state_n)
      S_START: sda_low_n = quarter_n[1];
      S_ADDR: begin
        scl_n     = quarter_n[1];
        sda_low_n = ~addr_n[7];
      end
      S_ACK1, S_ACK2: scl_n = quarter_n[1];
      S_DATA: begin
        scl_n     = quarter_n[1];
        sda_low_n = ~rw_n & ~data_n[7];
      end
      S_STOP: begin
        scl_n     = quarter_n[1];
        sda_low_n = (quarter_n != 2'd3);
      end
      default: begin
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: an I2C slave model on the bus plus a transaction-level
// reference model of expected bus bits, latency, ack_err and rd_data.
module tb_i2c_master_byte;

  localparam int unsigned CLK_DIV = 4;
  localparam int BIT_CLKS = 4 * CLK_DIV;
  localparam int LIMIT    = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, done, ack_err, scl;
  logic [7:0] rd_data;
  wire        sda_w;
  logic       sda_drv = 1'b0;

  pullup (sda_w);
  assign sda_w = sda_drv ? 1'b0 : 1'bz;

  int total = 0;
  int bad   = 0;

  logic [6:0] slv_addr = 7'h08;
  logic [7:0] slv_rd = 8'h00;
  logic       slv_nack_data = 1'b0;
  logic [7:0] rd_model = 8'h00;

  logic bits_q[$];
  int   start_cnt = 0;
  int   stop_cnt = 0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  logic cur_sda;
  int   k = 0;
  logic [7:0] rx_sh = 8'h00;
  logic hit = 1'b0;
  logic rd_mode = 1'b0;

  always #5 clk = ~clk;

  i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
    .busy(busy), .done(done), .ack_err(ack_err), .rd_data(rd_data),
    .i2c_scl(scl), .i2c_sda(sda_w)
  );

  // Slave model and bus monitor: records SDA at each SCL rise, counts START/STOP
  always @(negedge clk) begin
    cur_sda = sda_w;
    if (prev_scl && scl && prev_sda && !cur_sda) begin
      start_cnt++;
      k = 0; hit = 1'b0; rd_mode = 1'b0; sda_drv = 1'b0;
    end else if (prev_scl && scl && !prev_sda && cur_sda) begin
      stop_cnt++;
      k = 0; sda_drv = 1'b0;
    end else if (!prev_scl && scl) begin
      bits_q.push_back(cur_sda);
      k++;
      if (k <= 8) rx_sh = {rx_sh[6:0], cur_sda};
      if (k == 8) begin
        hit = (rx_sh[7:1] == slv_addr);
        rd_mode = rx_sh[0];
      end
    end else if (prev_scl && !scl) begin
      sda_drv = 1'b0;
      if (hit) begin
        if (k == 8) sda_drv = 1'b1;
        else if (rd_mode && k >= 9 && k <= 16) sda_drv = !slv_rd[16-k];
        else if (!rd_mode && k == 17 && !slv_nack_data) sda_drv = 1'b1;
      end
    end
    prev_scl = scl;
    prev_sda = cur_sda;
  end

  // Reference: bits on SCL rises, latency, ack_err for one command
  function automatic void model(input logic [6:0] a, input logic r, input logic [7:0] d,
                                output logic [17:0] eb, output int nb, output int lat,
                                output logic err);
    logic ack_a;
    ack_a = (a == slv_addr);
    if (!ack_a) begin
      eb = {9'b0, a, r, 1'b1};
      nb = 9;
      lat = 11 * BIT_CLKS;
      err = 1'b1;
    end else begin
      eb = {a, r, 1'b0, (r ? slv_rd : d), (r ? 1'b1 : slv_nack_data)};
      nb = 18;
      lat = 20 * BIT_CLKS;
      err = !r && slv_nack_data;
    end
  endfunction

  function automatic logic [17:0] bus_bits(input int base, input int n);
    logic [17:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      if (base + i < bits_q.size()) v = {v[16:0], bits_q[base+i]};
    return v;
  endfunction

  // Issue one command from a negedge; returns at the negedge where done is seen
  task automatic run_cmd(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input bit hold, input bit pulse,
                         output int wait_n, output int lat,
                         output logic b0, output logic r0, output logic e0, output logic to);
    cmd_addr = a; cmd_rw = r; cmd_data = d; cmd_valid = 1'b1;
    wait_n = 0;
    while (cmd_ready !== 1'b1 && wait_n < LIMIT) begin
      @(negedge clk); wait_n++;
    end
    @(negedge clk);
    b0 = busy; r0 = cmd_ready; e0 = ack_err;
    if (!hold) cmd_valid = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (pulse) begin
        cmd_valid = ((lat % 37) < 2);
        cmd_addr = ~a; cmd_data = ~d;
      end
      @(negedge clk); lat++;
    end
    if (pulse) begin
      cmd_valid = 1'b0; cmd_addr = a; cmd_data = d;
    end
    to = (wait_n >= LIMIT) || (lat >= LIMIT);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd_model = 8'h00;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    total++;
    if ({busy, done, ack_err} !== 3'b000) begin
      bad++; $display("FAIL reset_busy_done_err got=%b want=000", {busy, done, ack_err});
    end
    total++;
    if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
    total++;
    if ({scl, sda_w} !== 2'b11) begin bad++; $display("FAIL reset_bus got=%b want=11", {scl, sda_w}); end
  endtask

  task automatic test_write();
    logic [17:0] eb; int nb, elat; logic eerr;
    int base, s0, p0, n, lat; logic b0, r0, e0, to;
    slv_nack_data = 1'b0;
    model(7'h08, 1'b0, 8'hA5, eb, nb, elat, eerr);
    base = bits_q.size(); s0 = start_cnt; p0 = stop_cnt;
    run_cmd(7'h08, 1'b0, 8'hA5, 1'b0, 1'b1, n, lat, b0, r0, e0, to);
    total++;
    if (to || lat != elat) begin bad++; $display("FAIL write_latency got=%0d want=%0d", lat, elat); end
    total++;
    if ({b0, r0, e0} !== 3'b100) begin bad++; $display("FAIL write_accept busy/ready/err got=%b want=100", {b0, r0, e0}); end
    total++;
    if (ack_err !== eerr || busy !== 1'b0) begin
      bad++; $display("FAIL write_done_status err=%b busy=%b want err=%b busy=0", ack_err, busy, eerr);
    end
    total++;
    if (bus_bits(base, nb) !== eb || bits_q.size() - base != nb + 1) begin
      bad++; $display("FAIL write_bus_bits got=%b (%0d rises) want=%b (%0d rises)",
                      bus_bits(base, nb), bits_q.size() - base, eb, nb + 1);
    end
    total++;
    if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
      bad++; $display("FAIL write_start_stop got=%0d/%0d want=1/1", start_cnt - s0, stop_cnt - p0);
    end
    @(negedge clk);
    total++;
    if ({done, cmd_ready} !== 2'b01) begin bad++; $display("FAIL write_done_pulse done/ready got=%b want=01", {done, cmd_ready}); end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_pulses_ignored busy=%b want=0", busy); end
  endtask

  task automatic test_addr_nack();
    logic [17:0] eb; int nb, elat; logic eerr;
    int base, p0, n, lat; logic b0, r0, e0, to;
    model(7'h09, 1'b0, 8'h5A, eb, nb, elat, eerr);
    base = bits_q.size(); p0 = stop_cnt;
    run_cmd(7'h09, 1'b0, 8'h5A, 1'b0, 1'b0, n, lat, b0, r0, e0, to);
    total++;
    if (to || lat != elat) begin bad++; $display("FAIL nack_latency got=%0d want=%0d", lat, elat); end
    total++;
    if (ack_err !== eerr) begin bad++; $display("FAIL nack_ack_err got=%b want=%b", ack_err, eerr); end
    total++;
    if (bus_bits(base, nb) !== eb || bits_q.size() - base != nb + 1 || stop_cnt - p0 != 1) begin
      bad++; $display("FAIL nack_bus got=%b rises=%0d stops=%0d want=%b rises=%0d stops=1",
                      bus_bits(base, nb), bits_q.size() - base, stop_cnt - p0, eb, nb + 1);
    end
    repeat (5) @(negedge clk);
    total++;
    if (ack_err !== 1'b1) begin bad++; $display("FAIL nack_ack_err_hold got=%b want=1", ack_err); end
  endtask

  task automatic test_read();
    logic [17:0] eb; int nb, elat; logic eerr;
    int base, n, lat; logic b0, r0, e0, to;
    slv_rd = 8'h3C;
    model(7'h08, 1'b1, 8'hFF, eb, nb, elat, eerr);
    rd_model = slv_rd;
    base = bits_q.size();
    run_cmd(7'h08, 1'b1, 8'hFF, 1'b0, 1'b0, n, lat, b0, r0, e0, to);
    total++;
    if (e0 !== 1'b0) begin bad++; $display("FAIL read_err_clear_on_accept got=%b want=0", e0); end
    total++;
    if (to || lat != elat) begin bad++; $display("FAIL read_latency got=%0d want=%0d", lat, elat); end
    total++;
    if (rd_data !== rd_model || ack_err !== eerr) begin
      bad++; $display("FAIL read_result rd=%h err=%b want rd=%h err=%b", rd_data, ack_err, rd_model, eerr);
    end
    total++;
    if (bus_bits(base, nb) !== eb) begin bad++; $display("FAIL read_bus_bits got=%b want=%b", bus_bits(base, nb), eb); end
  endtask

  task automatic test_data_nack();
    logic [17:0] eb; int nb, elat; logic eerr;
    int base, p0, n, lat; logic b0, r0, e0, to;
    slv_nack_data = 1'b1;
    model(7'h08, 1'b0, 8'h77, eb, nb, elat, eerr);
    base = bits_q.size(); p0 = stop_cnt;
    run_cmd(7'h08, 1'b0, 8'h77, 1'b0, 1'b0, n, lat, b0, r0, e0, to);
    slv_nack_data = 1'b0;
    total++;
    if (to || lat != elat) begin bad++; $display("FAIL dnack_latency got=%0d want=%0d", lat, elat); end
    total++;
    if (ack_err !== eerr || rd_data !== rd_model) begin
      bad++; $display("FAIL dnack_status err=%b rd=%h want err=%b rd=%h", ack_err, rd_data, eerr, rd_model);
    end
    total++;
    if (bus_bits(base, nb) !== eb || stop_cnt - p0 != 1) begin
      bad++; $display("FAIL dnack_bus got=%b stops=%0d want=%b stops=1", bus_bits(base, nb), stop_cnt - p0, eb);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] eb1, eb2; int nb, elat; logic eerr;
    int base1, base2, s0, n, lat1, lat2; logic b0, r0, e0, to;
    slv_nack_data = 1'b0;
    base1 = bits_q.size(); s0 = start_cnt;
    run_cmd(7'h08, 1'b0, 8'h11, 1'b1, 1'b0, n, lat1, b0, r0, e0, to);
    model(7'h08, 1'b0, 8'h11, eb1, nb, elat, eerr);
    total++;
    if (to || lat1 != elat) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat1, elat); end
    cmd_data = 8'h22;
    base2 = bits_q.size();
    @(negedge clk);
    total++;
    if ({cmd_valid, cmd_ready} !== 2'b11) begin
      bad++; $display("FAIL b2b_accept_after_done valid/ready got=%b want=11", {cmd_valid, cmd_ready});
    end
    run_cmd(7'h08, 1'b0, 8'h22, 1'b0, 1'b0, n, lat2, b0, r0, e0, to);
    model(7'h08, 1'b0, 8'h22, eb2, nb, elat, eerr);
    total++;
    if (n != 0 || b0 !== 1'b1) begin bad++; $display("FAIL b2b_second_accept wait=%0d busy=%b want 0/1", n, b0); end
    total++;
    if (to || lat2 != elat || ack_err !== eerr) begin
      bad++; $display("FAIL b2b_second_done lat=%0d err=%b want lat=%0d err=%b", lat2, ack_err, elat, eerr);
    end
    total++;
    if (bus_bits(base1, nb) !== eb1 || bus_bits(base2, nb) !== eb2 || start_cnt - s0 != 2) begin
      bad++; $display("FAIL b2b_bus first=%b second=%b starts=%0d want %b %b 2",
                      bus_bits(base1, nb), bus_bits(base2, nb), start_cnt - s0, eb1, eb2);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] eb; int nb, elat; logic eerr;
    int base, p0, n, lat; logic b0, r0, e0, to; bit saw_done;
    slv_nack_data = 1'b0;
    cmd_addr = 7'h08; cmd_rw = 1'b0; cmd_data = 8'hC3; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    base = bits_q.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    while (bits_q.size() < base + 12 && n < LIMIT) begin @(negedge clk); n++; end
    while (scl !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
    total++;
    if (n >= LIMIT) begin bad++; $display("FAIL rstmid_reach_data_bit3 timeout after %0d cycles", n); end
    p0 = stop_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_model = 8'h00;
    total++;
    if ({scl, sda_w, busy, cmd_ready, done} !== 5'b11010) begin
      bad++; $display("FAIL rstmid_abort scl/sda/busy/ready/done got=%b want=11010", {scl, sda_w, busy, cmd_ready, done});
    end
    total++;
    if (rd_data !== 8'h00 || ack_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_status rd=%h err=%b want 00/0", rd_data, ack_err);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done || stop_cnt != p0) begin
      bad++; $display("FAIL rstmid_no_done_no_stop done_seen=%b stops=%0d want 0/0", saw_done, stop_cnt - p0);
    end
    model(7'h08, 1'b0, 8'h5A, eb, nb, elat, eerr);
    base = bits_q.size();
    run_cmd(7'h08, 1'b0, 8'h5A, 1'b0, 1'b0, n, lat, b0, r0, e0, to);
    total++;
    if (to || lat != elat || ack_err !== eerr || bus_bits(base, nb) !== eb) begin
      bad++; $display("FAIL rstmid_recover lat=%0d err=%b bits=%b want lat=%0d err=%b bits=%b",
                      lat, ack_err, bus_bits(base, nb), elat, eerr, eb);
    end
  endtask

  task automatic test_random();
    logic [17:0] eb; int nb, elat; logic eerr;
    int base, n, lat; logic b0, r0, e0, to;
    logic [6:0] a; logic r; logic [7:0] d;
    for (int t = 0; t < 8; t++) begin
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h08;
      if (r) a = 7'h08;
      d = 8'($urandom);
      slv_rd = 8'($urandom);
      slv_nack_data = ($urandom_range(0, 3) == 0);
      model(a, r, d, eb, nb, elat, eerr);
      if (r && a == slv_addr) rd_model = slv_rd;
      base = bits_q.size();
      run_cmd(a, r, d, 1'b0, 1'b0, n, lat, b0, r0, e0, to);
      total++;
      if (to || lat != elat) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", t, lat, elat); end
      total++;
      if (ack_err !== eerr) begin bad++; $display("FAIL rand%0d_ack_err got=%b want=%b", t, ack_err, eerr); end
      total++;
      if (rd_data !== rd_model) begin bad++; $display("FAIL rand%0d_rd_data got=%h want=%h", t, rd_data, rd_model); end
      total++;
      if (bus_bits(base, nb) !== eb) begin bad++; $display("FAIL rand%0d_bus_bits got=%b want=%b", t, bus_bits(base, nb), eb); end
    end
    slv_nack_data = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_nack();
    test_read();
    test_data_nack();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1);
  end

endmodule
